krnl_vadd_ctrl: RTL
===================

# krnl_vadd_ctrl

Control sequencer for the vector-add RTL kernel. It accepts the ap_ctrl_hs start/done handshake and kernel arguments from the AXI4-Lite control slave, splits the vector length into bursts, and issues read commands for operands A and B and write commands for result C to the gmem AXI4 master engines. It counts write completions, signals kernel completion and drives the host interrupt.

## Interface
Parameters:
- C_ADDR_WIDTH, 64: gmem byte-address width.
- C_LEN_WIDTH, 32: width of the length argument and the internal counters.
- C_BURST_BEATS, 16: maximum beats per burst; power of two, 2..256.
- C_BYTES_PER_BEAT, 64: gmem data bytes per beat.

Ports (BW = $clog2(C_BURST_BEATS)+1):
- ap_clk  in  1  kernel clock; all logic is on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  start request from the control slave.
- ap_idle  out  1  high when no run is in progress.
- ap_ready  out  1  one-cycle pulse: arguments latched.
- ap_done  out  1  one-cycle pulse: run complete.
- cfg_length  in  C_LEN_WIDTH  vector length in beats.
- cfg_a_addr, cfg_b_addr, cfg_c_addr  in  C_ADDR_WIDTH  base byte addresses.
- int_en  in  1  interrupt enable.
- int_clr  in  1  interrupt clear pulse.
- interrupt  out  1  sticky done interrupt.
- rd_cmd_valid  out  1, rd_cmd_ready  in  1  read-command handshake.
- rd_cmd_sel  out  1  operand select: 0 = A, 1 = B.
- rd_cmd_addr  out  C_ADDR_WIDTH; rd_cmd_beats  out  BW.
- wr_cmd_valid  out  1, wr_cmd_ready  in  1  write-command handshake.
- wr_cmd_addr  out  C_ADDR_WIDTH; wr_cmd_beats  out  BW.
- wr_done  in  1  one-cycle pulse per completed write burst (B response).

## Operation
- States: IDLE, RD_A, RD_B, WR, WAIT, DONE.
- IDLE: ap_idle=1. On ap_start=1, latch all cfg_* and clear counters. Go to DONE if cfg_length==0, otherwise to RD_A.
- Per chunk: beats = min(remaining, C_BURST_BEATS). The state sequence is RD_A (sel=0, addr=a_ptr), then RD_B (sel=1, addr=b_ptr), then WR (addr=c_ptr).
- A state advances only on valid&&ready. On that handshake the pointer advances by beats*C_BYTES_PER_BEAT.
- After the WR handshake: remaining -= beats and issued += 1. Go to RD_A if remaining != 0, otherwise to WAIT.
- The wr_done counter increments on every wr_done pulse in any non-IDLE state. wr_done in IDLE is ignored.
- WAIT: when completed == issued, go to DONE. A wr_done that arrives during RD_A/RD_B/WR is counted and is not lost.
- DONE: ap_done=1 for one cycle, then IDLE.
- interrupt: set in the DONE cycle if int_en=1. Cleared by int_clr. If set and clear coincide, set wins.
- Base addresses must be aligned to C_BURST_BEATS*C_BYTES_PER_BEAT so that no burst crosses 4 KB. The block does not check this.
- Pointer arithmetic wraps modulo 2^C_ADDR_WIDTH.
- ap_start held high across DONE→IDLE starts a new run. The run starts in the IDLE cycle that follows DONE.

## Timing
- Reset values: ap_idle=1, and 0 for ap_ready, ap_done, interrupt, rd_cmd_valid, wr_cmd_valid, rd_cmd_sel, all addr and beats outputs. State=IDLE, counters=0.
- Reset asserted mid-run: immediate return to reset values. Any in-flight commands are abandoned.
- ap_start sampled in cycle N (IDLE) gives:
  - ap_ready=1 and ap_idle=0 in cycle N+1.
  - rd_cmd_valid=1 (A) in N+1.
- With ready held high, the command pattern is one command per cycle (A, B, C, A, ...).
- Command outputs are registered. Valid, sel, addr and beats stay stable while valid && !ready.
- Valid drops the cycle after the handshake unless the next state is also a command state.
- Zero length: ap_ready in N+1, ap_done in N+2, ap_idle=1 in N+3. No commands are issued.
- Last wr_done arriving in cycle M while in WAIT gives ap_done in M+1 and ap_idle=1 in M+2.
- If the final wr_done arrives in the same cycle as the last WR handshake, the count includes it, and ap_done follows WAIT one cycle later.

## Test plan
- length=40, A=0x1000, B=0x2000, C=0x3000, ready=1, each wr_done 3 cycles after its wr handshake. Required commands:
  - chunk 1: A@0x1000/16, B@0x2000/16, C@0x3000/16
  - chunk 2: A@0x1400/16, B@0x2400/16, C@0x3400/16
  - chunk 3: A@0x1800/8, B@0x2800/8, C@0x3800/8
  - then a single ap_done pulse.
- length=0, start in cycle 10: ap_ready in 11, ap_done in 12, no rd/wr valid ever.
- rd_cmd_ready held low 5 cycles on the B command: sel, addr and beats stable throughout, exactly one B handshake.
- All three wr_done pulses delayed 20 cycles after the last WR handshake: ap_done exactly one cycle after the third pulse. A wr_done pulse in IDLE does not alter the next run.
- int_en=1 run completes, then int_clr pulsed in the same cycle as the next DONE: interrupt stays 1. A later lone int_clr drives it to 0.
- ap_rst_n low for 1 cycle mid-chunk 2: all outputs at reset values immediately. A new start with length=16 gives one A, one B and one C command and ap_done.

Source files
------------

// File: rtl/krnl_vadd_ctrl.sv
// Vector-add kernel control sequencer: ap_ctrl_hs handshake, burst splitting,
// A/B read and C write command issue, write-completion tracking and interrupt.
module krnl_vadd_ctrl #(
    parameter int unsigned C_ADDR_WIDTH     = 64,
    parameter int unsigned C_LEN_WIDTH      = 32,
    parameter int unsigned C_BURST_BEATS    = 16,
    parameter int unsigned C_BYTES_PER_BEAT = 64,
    localparam int unsigned BW              = $clog2(C_BURST_BEATS) + 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_start,
    output logic                    ap_idle,
    output logic                    ap_ready,
    output logic                    ap_done,
    input  logic [C_LEN_WIDTH-1:0]  cfg_length,
    input  logic [C_ADDR_WIDTH-1:0] cfg_a_addr,
    input  logic [C_ADDR_WIDTH-1:0] cfg_b_addr,
    input  logic [C_ADDR_WIDTH-1:0] cfg_c_addr,
    input  logic                    int_en,
    input  logic                    int_clr,
    output logic                    interrupt,
    output logic                    rd_cmd_valid,
    input  logic                    rd_cmd_ready,
    output logic                    rd_cmd_sel,
    output logic [C_ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [BW-1:0]           rd_cmd_beats,
    output logic                    wr_cmd_valid,
    input  logic                    wr_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [BW-1:0]           wr_cmd_beats,
    input  logic                    wr_done
);

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StWr, StWait, StDone} state_e;

    state_e                  state;
    logic [C_ADDR_WIDTH-1:0] a_ptr, b_ptr, c_ptr;
    logic [C_LEN_WIDTH-1:0]  remaining, issued, completed;
    logic [C_LEN_WIDTH-1:0]  completed_next, remaining_next;

    // Burst size for the next chunk: min(remaining, C_BURST_BEATS).
    function automatic logic [BW-1:0] chunk_beats(input logic [C_LEN_WIDTH-1:0] rem);
        if (rem >= C_LEN_WIDTH'(C_BURST_BEATS)) return BW'(C_BURST_BEATS);
        return rem[BW-1:0];
    endfunction

    // Byte distance covered by one burst; wraps modulo the address width.
    function automatic logic [C_ADDR_WIDTH-1:0] burst_bytes(input logic [BW-1:0] beats);
        return C_ADDR_WIDTH'(beats) * C_ADDR_WIDTH'(C_BYTES_PER_BEAT);
    endfunction

    // Completion count including a pulse arriving this cycle, so WAIT never misses it.
    always_comb begin
        completed_next = completed + C_LEN_WIDTH'(wr_done);
        remaining_next = remaining - C_LEN_WIDTH'(wr_cmd_beats);
    end

    // Main sequencer with registered handshake and command outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state        <= StIdle;
            ap_idle      <= 1'b1;
            ap_ready     <= 1'b0;
            ap_done      <= 1'b0;
            interrupt    <= 1'b0;
            rd_cmd_valid <= 1'b0;
            rd_cmd_sel   <= 1'b0;
            rd_cmd_addr  <= '0;
            rd_cmd_beats <= '0;
            wr_cmd_valid <= 1'b0;
            wr_cmd_addr  <= '0;
            wr_cmd_beats <= '0;
            a_ptr        <= '0;
            b_ptr        <= '0;
            c_ptr        <= '0;
            remaining    <= '0;
            issued       <= '0;
            completed    <= '0;
        end else begin
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;

            // wr_done is counted in every run state, ignored in IDLE.
            if (state != StIdle && wr_done) completed <= completed_next;

            // Set has priority over clear.
            if (state == StDone && int_en) interrupt <= 1'b1;
            else if (int_clr)              interrupt <= 1'b0;

            case (state)
                StIdle: begin
                    if (ap_start) begin
                        a_ptr     <= cfg_a_addr;
                        b_ptr     <= cfg_b_addr;
                        c_ptr     <= cfg_c_addr;
                        remaining <= cfg_length;
                        issued    <= '0;
                        completed <= '0;
                        ap_ready  <= 1'b1;
                        ap_idle   <= 1'b0;
                        if (cfg_length == '0) begin
                            // Counts are already equal, so WAIT falls straight to DONE,
                            // placing ap_done two cycles after the start sample.
                            state <= StWait;
                        end else begin
                            state        <= StRdA;
                            rd_cmd_valid <= 1'b1;
                            rd_cmd_sel   <= 1'b0;
                            rd_cmd_addr  <= cfg_a_addr;
                            rd_cmd_beats <= chunk_beats(cfg_length);
                        end
                    end
                end
                StRdA: begin
                    if (rd_cmd_ready) begin
                        a_ptr       <= a_ptr + burst_bytes(rd_cmd_beats);
                        rd_cmd_sel  <= 1'b1;
                        rd_cmd_addr <= b_ptr;
                        state       <= StRdB;
                    end
                end
                StRdB: begin
                    if (rd_cmd_ready) begin
                        b_ptr        <= b_ptr + burst_bytes(rd_cmd_beats);
                        rd_cmd_valid <= 1'b0;
                        wr_cmd_valid <= 1'b1;
                        wr_cmd_addr  <= c_ptr;
                        wr_cmd_beats <= rd_cmd_beats;
                        state        <= StWr;
                    end
                end
                StWr: begin
                    if (wr_cmd_ready) begin
                        c_ptr        <= c_ptr + burst_bytes(wr_cmd_beats);
                        remaining    <= remaining_next;
                        issued       <= issued + C_LEN_WIDTH'(1);
                        wr_cmd_valid <= 1'b0;
                        if (remaining_next != '0) begin
                            state        <= StRdA;
                            rd_cmd_valid <= 1'b1;
                            rd_cmd_sel   <= 1'b0;
                            rd_cmd_addr  <= a_ptr;
                            rd_cmd_beats <= chunk_beats(remaining_next);
                        end else begin
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    // issued==0 only for zero length; guards against a stray pulse.
                    if (completed_next == issued || issued == '0) begin
                        state   <= StDone;
                        ap_done <= 1'b1;
                    end
                end
                StDone: begin
                    state   <= StIdle;
                    ap_idle <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
